// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the excitation helper used by JK-based counters.
// Encodings are written as {J, K}.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Counting only ever toggles or holds, so a changing bit always gets the toggle pair.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        if (cur != nxt) begin
            return JK_TOG;
        end
        return JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// Single-bit rising-edge JK flip-flop with asynchronous active-high reset.
module jk_stage
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TOG:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter whose state lives in WIDTH JK stages; this block only
// computes the J/K excitation, terminal count and the registered wrap pulse.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] j_x,
    output logic [WIDTH-1:0] k_x,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("jk_sync_counter: WIDTH must be in 2..16");
    end
    if (MOD < 2 || MOD > (32'd1 << WIDTH)) begin : g_bad_mod
        $error("jk_sync_counter: MOD must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

    logic [31:0]      q_ext;
    logic             at_top;
    logic             at_zero;
    logic             out_rng;
    logic             wrap_cond;
    logic [WIDTH-1:0] nxt;
    logic             wrap_q;
    logic             wrap_d;

    // Compare in 32 bits so MOD = 2**WIDTH never aliases onto a WIDTH-bit value.
    assign q_ext   = 32'(q);
    assign at_top  = (q_ext >= (MOD - 1));
    assign out_rng = (q_ext >= MOD);
    assign at_zero = (q == '0);

    always_comb begin
        nxt       = q;
        wrap_cond = 1'b0;
        if (up) begin
            wrap_cond = at_top;
            nxt       = at_top ? '0 : q + 1'b1;
        end else begin
            wrap_cond = at_zero | out_rng;
            nxt       = (at_zero | out_rng) ? MaxVal : q - 1'b1;
        end
    end

    always_comb begin
        j_x = '0;
        k_x = '0;
        tc  = 1'b0;
        if (load) begin
            j_x = din;
            k_x = ~din;
        end else if (en) begin
            tc = wrap_cond;
            for (int i = 0; i < int'(WIDTH); i++) begin
                {j_x[i], k_x[i]} = jk_excite(q[i], nxt[i]);
            end
        end
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_stage
        jk_stage u_stage (
            .clk  (clk),
            .rst  (rst),
            .j    (j_x[gi]),
            .k    (k_x[gi]),
            .q    (q[gi]),
            .qbar (qbar[gi])
        );
    end

    assign wrap_d = tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed and randomized bench for jk_sync_counter (WIDTH=4, MOD=10) against an
// integer reference model of the counting rules.
module tb_jk_sync_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] j_x;
    logic [WIDTH-1:0] k_x;
    logic             tc;
    logic             wrap;

    int checks = 0;
    int errors = 0;
    int exp_q  = 0;
    bit exp_wrap = 1'b0;

    jk_sync_counter #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .qbar (qbar),
        .j_x  (j_x),
        .k_x  (k_x),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int m_next(int cur, bit e, bit u, bit l, int d);
        if (l) return d;
        if (!e) return cur;
        if (u) return (cur >= MOD - 1) ? 0 : cur + 1;
        return (cur == 0 || cur >= MOD) ? MOD - 1 : cur - 1;
    endfunction

    function automatic bit m_tc(int cur, bit e, bit u, bit l);
        if (l || !e) return 1'b0;
        if (u) return cur >= MOD - 1;
        return (cur == 0) || (cur >= MOD);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs, check all outputs before the edge, then advance the model.
    task automatic cycle(input string tag, input bit e, input bit u, input bit l, input int d);
        int nx;
        int jx;
        int kx;
        en   = e;
        up   = u;
        load = l;
        din  = d[WIDTH-1:0];
        #1;
        nx = m_next(exp_q, e, u, l, d);
        if (l) begin
            jx = d;
            kx = ~d & 15;
        end else if (e) begin
            jx = exp_q ^ nx;
            kx = exp_q ^ nx;
        end else begin
            jx = 0;
            kx = 0;
        end
        chk({tag, ".q"}, 32'(q), exp_q);
        chk({tag, ".qbar"}, 32'(qbar), ~exp_q & 15);
        chk({tag, ".tc"}, 32'(tc), 32'(m_tc(exp_q, e, u, l)));
        chk({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        chk({tag, ".j_x"}, 32'(j_x), jx);
        chk({tag, ".k_x"}, 32'(k_x), kx);
        @(posedge clk);
        exp_wrap = m_tc(exp_q, e, u, l);
        exp_q    = nx;
        #1;
    endtask

    // Pulse rst between edges and confirm the state clears without a clock.
    task automatic async_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        chk({tag, ".q"}, 32'(q), 0);
        chk({tag, ".qbar"}, 32'(qbar), 15);
        chk({tag, ".wrap"}, 32'(wrap), 0);
        chk({tag, ".tc"}, 32'(tc), 32'(m_tc(0, en, up, load)));
        rst      = 1'b0;
        exp_q    = 0;
        exp_wrap = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        din  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.q", 32'(q), 0);
        chk("reset.qbar", 32'(qbar), 15);
        chk("reset.wrap", 32'(wrap), 0);
        chk("reset.tc", 32'(tc), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Async reset while q=7.
        cycle("ld7", 1'b0, 1'b1, 1'b1, 7);
        chk("ld7.val", 32'(q), 7);
        async_reset("rst_q7");

        // Up count from 0 across the wrap.
        for (int i = 0; i < 12; i++) cycle("up", 1'b1, 1'b1, 1'b0, 0);
        chk("up12.val", 32'(q), 2);

        // Down count from 2 through zero.
        cycle("dn", 1'b1, 1'b0, 1'b0, 0);
        cycle("dn", 1'b1, 1'b0, 1'b0, 0);
        en = 1'b1;
        up = 1'b0;
        #1;
        chk("dn0.j_x", 32'(j_x), 32'h9);
        chk("dn0.k_x", 32'(k_x), 32'h9);
        chk("dn0.tc", 32'(tc), 1);
        cycle("dn", 1'b1, 1'b0, 1'b0, 0);
        cycle("dn", 1'b1, 1'b0, 1'b0, 0);
        chk("dn4.val", 32'(q), 8);

        // Load beats enable.
        cycle("ld5", 1'b1, 1'b1, 1'b1, 5);
        chk("ld5.val", 32'(q), 5);

        // Out-of-range load recovers up and down.
        cycle("ld13u", 1'b0, 1'b1, 1'b1, 13);
        cycle("oor_up", 1'b1, 1'b1, 1'b0, 0);
        chk("oor_up.val", 32'(q), 0);
        cycle("ld13d", 1'b0, 1'b1, 1'b1, 13);
        cycle("oor_dn", 1'b1, 1'b0, 1'b0, 0);
        chk("oor_dn.val", 32'(q), 9);

        // Hold at 4.
        cycle("ld4", 1'b0, 1'b1, 1'b1, 4);
        for (int i = 0; i < 5; i++) cycle("hold", 1'b0, i[0], 1'b0, 0);
        chk("hold.val", 32'(q), 4);

        // Reset while a wrap pulse is in flight.
        cycle("ld9", 1'b0, 1'b1, 1'b1, 9);
        cycle("wrapup", 1'b1, 1'b1, 1'b0, 0);
        chk("inflight.wrap", 32'(wrap), 1);
        async_reset("rst_wrap");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
